mul_result_serializer: RTL and testbench
========================================

// Module: mul_result_serializer
// PURPOSE
//  Downstream stage of the array multiplier. Accepts full-width products over a
//  valid/ready handshake and buffers them in a 2-entry FIFO. Streams each product
//  MSB-byte-first onto the 8-bit uo_out-side bus, advancing one byte per out_ack.
//  Decouples multiplier throughput from the slow pin-level consumer.
// PARAMETERS
//  PROD_W  16  product width in bits; must be a multiple of OUT_W
//  OUT_W   8   output byte width
//  DEPTH   2   FIFO entries; power of two, >=2
// PORTS
//  clk        in   1       single clock; all state on the rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       product valid from multiplier
//  in_data    in   PROD_W  product
//  in_ready   out  1       = !fifo_full; in_valid&&in_ready pushes in_data
//  out_byte   out  OUT_W   current byte (0 when !out_valid)
//  out_valid  out  1       out_byte is valid
//  out_last   out  1       current byte is the last (LSB) byte of the product
//  out_ack    in   1       consumer takes the byte; ignored when !out_valid
//  out_parity out  1       even parity of out_byte (see CONFIGURATION)
//  fifo_count out  $clog2(DEPTH)+1  FIFO occupancy, excluding the word in the shifter
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, state IDLE, shifter=0, beat=0.
//   out_valid=0, out_byte=0, out_last=0, out_parity=0, fifo_count=0, in_ready=1.
//   Reset mid-stream discards all buffered and partially sent words; no output glitch.
//  BEATS = PROD_W/OUT_W. beat counter is $clog2(BEATS) bits wide.
//  FIFO: push when in_valid&&in_ready; pop only when the FSM loads the shifter.
//   In the same cycle, push and pop are both legal when not full. No bypass exists
//   for a full FIFO: in_ready=0 while full, even if a pop occurs that cycle.
//   Data is order-preserving; wrap-around is handled by pointer MSB compare.
//  FSM states:
//   IDLE: out_valid=0. If the FIFO is non-empty: pop head into the shifter, beat=0, go to SEND.
//   SEND: out_valid=1, out_byte=shifter[PROD_W-1 -: OUT_W], out_last=(beat==BEATS-1).
//     out_ack && !out_last: shift left by OUT_W, beat++.
//     out_ack && out_last: if the FIFO is non-empty, pop and reload (no bubble,
//     beat=0) and stay in SEND; else go to IDLE.
//  Latency: a push into an empty FIFO at edge N makes out_valid high after edge N+1
//   (2 cycles). Back-to-back products stream with zero idle cycles between them.
//  out_byte, out_last and out_valid are registered/state-derived. out_ack does not
//   combinationally affect them.
// CONFIGURATION
//  MUL_SER_PARITY_EN defined: out_parity = ^out_byte while out_valid, else 0.
//  Not defined: out_parity tied to 0 and no parity logic is generated.
// STRUCTURE
//  Package mul_ser_pkg: state enum {IDLE, SEND}, the default PROD_W/OUT_W/DEPTH
//   constants, and the BEATS localparam function.
//  Sub-module mul_ser_fifo: DEPTH x PROD_W synchronous FIFO with full, empty and
//   count outputs. The FSM and shifter stay in the top module.
// TESTING
//  1. Reset, push 16'hA5C3, hold out_ack=1 -> bytes A5 (last=0) then C3 (last=1); then out_valid=0.
//  2. Push 16'h1234, 16'h5678, 16'h9ABC with out_ack=0 -> in_ready drops after the 3rd push
//     (2 in FIFO + 1 in shifter); fifo_count=2.
//  3. Ack continuously after case 2 -> 12,34,56,78,9A,BC with no gap cycles; in_ready returns to 1.
//  4. Pulse rst_n low after the first byte of 16'hFFEE -> out_valid=0 immediately;
//     fifo_count=0; EE is never emitted.
//  5. Push while popping at fifo_count=1 -> count holds at 1; order preserved across
//     pointer wrap (8 words).
//  6. MUL_SER_PARITY_EN: byte 8'h07 -> out_parity=1, 8'h03 -> 0; without the macro,
//     out_parity=0 always.

Source files
------------

// File: rtl/mul_ser_pkg.sv
// Shared types and default sizing for the multiplier result serializer.
// Optional feature macro: MUL_SER_PARITY_EN (see mul_result_serializer.sv).
package mul_ser_pkg;

    localparam int unsigned DefProdW = 16;
    localparam int unsigned DefOutW  = 8;
    localparam int unsigned DefDepth = 2;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // Number of output bytes needed to carry one product.
    function automatic int unsigned calc_beats(int unsigned prod_w, int unsigned out_w);
        return prod_w / out_w;
    endfunction

endpackage

// File: rtl/mul_ser_fifo.sv
// Small synchronous FIFO holding products waiting for the output shifter.
// Pointers carry one extra wrap bit so full/empty are told apart by the MSB.
module mul_ser_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Status derived from pointer distance and wrap bits.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                  (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        count_o = wr_ptr_q - rd_ptr_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        data_o  = mem_q[rd_ptr_q[AddrW-1:0]];
    end

    // Pointer advance; push and pop may happen in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end

endmodule

// File: rtl/mul_result_serializer.sv
// Buffers multiplier products and streams them MSB-byte-first, one byte per out_ack.
// Optional feature: define MUL_SER_PARITY_EN to drive out_parity with even parity
// of out_byte; otherwise out_parity is tied low.
module mul_result_serializer
    import mul_ser_pkg::*;
#(
    parameter int unsigned PROD_W = DefProdW,
    parameter int unsigned OUT_W  = DefOutW,
    parameter int unsigned DEPTH  = DefDepth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [PROD_W-1:0]      in_data,
    output logic                   in_ready,
    output logic [OUT_W-1:0]       out_byte,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ack,
    output logic                   out_parity,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned BEATS      = calc_beats(PROD_W, OUT_W);
    localparam int unsigned BeatW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
    localparam bit          SingleBeat = (BEATS == 1);

    state_e             state_q;
    logic [PROD_W-1:0]  shifter_q;
    logic [BeatW-1:0]   beat_q;
    logic               out_valid_q;
    logic               out_last_q;

    logic [PROD_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;

    // Handshake and pop decision; pop only when the shifter is (re)loaded.
    always_comb begin
        in_ready  = !fifo_full;
        fifo_push = in_valid && in_ready;
        fifo_pop  = !fifo_empty &&
                    ((state_q == StIdle) || (out_ack && out_last_q));
    end

    mul_ser_fifo #(
        .Width (PROD_W),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .data_i  (in_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Output FSM: loads the shifter, walks the beats, reloads without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shifter_q   <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q     <= StSend;
                        shifter_q   <= fifo_head;
                        beat_q      <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= SingleBeat;
                    end
                end
                StSend: begin
                    if (out_ack) begin
                        if (!out_last_q) begin
                            shifter_q  <= shifter_q << OUT_W;
                            beat_q     <= beat_q + 1'b1;
                            out_last_q <= ((beat_q + 1'b1) == LastBeat);
                        end else if (!fifo_empty) begin
                            shifter_q  <= fifo_head;
                            beat_q     <= '0;
                            out_last_q <= SingleBeat;
                        end else begin
                            // Clear the shifter so out_byte reads 0 while idle.
                            state_q     <= StIdle;
                            shifter_q   <= '0;
                            beat_q      <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs come straight from registers; out_ack has no combinational path here.
    always_comb begin
        out_valid = out_valid_q;
        out_last  = out_last_q;
        out_byte  = shifter_q[PROD_W-1 -: OUT_W];
    end

`ifdef MUL_SER_PARITY_EN
    // out_byte is already 0 while idle; the gate keeps the intent explicit.
    assign out_parity = out_valid_q & (^out_byte);
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_mul_result_serializer.sv
// Self-checking bench for mul_result_serializer: word/byte-level reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_mul_result_serializer;

    localparam int D     = 2;
    localparam int BEATS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ack = 1'b0;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_last;
    logic        out_parity;
    logic [1:0]  fifo_count;

    mul_result_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ack    (out_ack),
        .out_parity (out_parity),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

`ifdef MUL_SER_PARITY_EN
    localparam bit ParityOn = 1'b1;
`else
    localparam bit ParityOn = 1'b0;
`endif

    // Reference model: queue of buffered words, plus the word being sent.
    logic [15:0] mq[$];
    bit          m_busy = 0;
    logic [15:0] m_cur = '0;
    int          m_idx = 0;
    bit          m_push;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_busy = 0;
            m_cur  = '0;
            m_idx  = 0;
        end else begin
            m_push = in_valid && (mq.size() < D);
            if (m_busy) begin
                if (out_ack) begin
                    if (m_idx < BEATS - 1) m_idx++;
                    else if (mq.size() > 0) begin
                        m_cur = mq.pop_front();
                        m_idx = 0;
                    end else m_busy = 0;
                end
            end else if (mq.size() > 0) begin
                m_cur  = mq.pop_front();
                m_idx  = 0;
                m_busy = 1;
            end
            if (m_push) mq.push_back(in_data);
        end
    end

    function automatic int exp_byte();
        logic [15:0] sh;
        if (!m_busy) return 0;
        sh = m_cur >> (8 * (BEATS - 1 - m_idx));
        return int'(sh[7:0]);
    endfunction

    // Per-cycle compare away from the active edge, plus capture of consumed bytes.
    logic [7:0] got[$];
    bit         got_last[$];
    int         got_cyc[$];
    int         cyc = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(m_busy));
            chk("out_byte", int'(out_byte), exp_byte());
            chk("out_last", int'(out_last), int'(m_busy && (m_idx == BEATS - 1)));
            chk("in_ready", int'(in_ready), int'(mq.size() < D));
            chk("fifo_count", int'(fifo_count), mq.size());
            chk("out_parity", int'(out_parity),
                ParityOn ? int'(^exp_byte()) : 0);
            if (out_valid && out_ack) begin
                got.push_back(out_byte);
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_capture();
        got.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    task automatic push_word(input logic [15:0] w);
        int k;
        in_valid = 1'b1;
        in_data  = w;
        k = 0;
        while (!in_ready && k < 100) begin
            step(1);
            k++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        step(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 50; k++) begin
            if (out_valid) return;
            step(1);
        end
        chk("wait_valid_timeout", int'(out_valid), 1);
    endtask

    logic [15:0] words [8];

    initial begin
        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_byte", int'(out_byte), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_out_parity", int'(out_parity), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2);

        // 1: single product, continuous ack
        clear_capture();
        out_ack = 1'b1;
        push_word(16'hA5C3);
        step(4);
        chk("t1_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t1_b0", int'(got[0]), 'hA5);
            chk("t1_l0", int'(got_last[0]), 0);
            chk("t1_b1", int'(got[1]), 'hC3);
            chk("t1_l1", int'(got_last[1]), 1);
        end
        chk("t1_idle", int'(out_valid), 0);

        // 2: fill with no ack
        clear_capture();
        out_ack = 1'b0;
        push_word(16'h1234);
        push_word(16'h5678);
        push_word(16'h9ABC);
        step(1);
        chk("t2_fifo_count", int'(fifo_count), 2);
        chk("t2_in_ready", int'(in_ready), 0);
        chk("t2_byte", int'(out_byte), 'h12);

        // 3: drain with no gaps
        out_ack = 1'b1;
        step(8);
        chk("t3_count", got.size(), 6);
        if (got.size() == 6) begin
            chk("t3_b0", int'(got[0]), 'h12);
            chk("t3_b1", int'(got[1]), 'h34);
            chk("t3_b2", int'(got[2]), 'h56);
            chk("t3_b3", int'(got[3]), 'h78);
            chk("t3_b4", int'(got[4]), 'h9A);
            chk("t3_b5", int'(got[5]), 'hBC);
            chk("t3_nogap", got_cyc[5] - got_cyc[0], 5);
        end
        chk("t3_in_ready", int'(in_ready), 1);
        chk("t3_idle", int'(out_valid), 0);

        // 4: reset mid-stream
        clear_capture();
        out_ack = 1'b0;
        push_word(16'hFFEE);
        wait_valid();
        out_ack = 1'b1;
        step(1);
        out_ack = 1'b0;
        chk("t4_second_byte", int'(out_byte), 'hEE);
        rst_n = 1'b0;
        #1;
        chk("t4_valid", int'(out_valid), 0);
        chk("t4_fifo_count", int'(fifo_count), 0);
        chk("t4_byte", int'(out_byte), 0);
        #2;
        rst_n = 1'b1;
        out_ack = 1'b1;
        step(4);
        chk("t4_count", got.size(), 1);
        if (got.size() == 1) chk("t4_b0", int'(got[0]), 'hFF);
        chk("t4_idle", int'(out_valid), 0);

        // 5: order across pointer wrap with push/pop overlap
        clear_capture();
        out_ack = 1'b1;
        for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) push_word(words[i]);
        step(8);
        chk("t5_count", got.size(), 16);
        if (got.size() == 16)
            for (int i = 0; i < 8; i++)
                chk("t5_word", int'({got[2*i], got[2*i+1]}), int'(words[i]));

        // 6: parity
        clear_capture();
        out_ack = 1'b0;
        push_word(16'h0703);
        wait_valid();
        chk("t6_b0", int'(out_byte), 'h07);
        chk("t6_p0", int'(out_parity), ParityOn ? 1 : 0);
        out_ack = 1'b1;
        step(1);
        out_ack = 1'b0;
        chk("t6_b1", int'(out_byte), 'h03);
        chk("t6_p1", int'(out_parity), 0);
        chk("t6_last", int'(out_last), 1);
        out_ack = 1'b1;
        step(2);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            out_ack  = ($urandom_range(0, 3) != 0);
            step(1);
        end
        in_valid = 1'b0;
        out_ack  = 1'b1;
        step(10);
        chk("drain_idle", int'(out_valid), 0);
        chk("drain_count", int'(fifo_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
